// File: rtl/pe_feeder_pkg.sv
// Shared types for the PE feeder: FSM state encoding, stream tags and
// the helper that picks the next stream with work to do.
package pe_feeder_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILTER = 3'd1,
      IFMAP  = 3'd2,
      IPSUM  = 3'd3,
      DRAIN  = 3'd4,
      DONE   = 3'd5
   } state_t;

   typedef logic [1:0] tag_t;

   localparam tag_t TAG_FILTER = 2'd0;
   localparam tag_t TAG_IFMAP  = 2'd1;
   localparam tag_t TAG_IPSUM  = 2'd2;

   function automatic tag_t stateTag(input state_t s);
      tag_t t;
      case (s)
         IFMAP:   t = TAG_IFMAP;
         IPSUM:   t = TAG_IPSUM;
         default: t = TAG_FILTER;
      endcase
      return t;
   endfunction

   // Streams run in fixed order; DRAIN means nothing after the current one.
   function automatic state_t nextStream(input state_t cur, input logic hasFilter,
                                         input logic hasIfmap, input logic hasIpsum);
      state_t n;
      n = DRAIN;
      if (cur == IDLE && hasFilter)
         n = FILTER;
      else if ((cur == IDLE || cur == FILTER) && hasIfmap)
         n = IFMAP;
      else if ((cur == IDLE || cur == FILTER || cur == IFMAP) && hasIpsum)
         n = IPSUM;
      return n;
   endfunction

endpackage

// File: rtl/feeder_skid_buffer.sv
// Two-entry tagged FIFO that catches global-buffer read data so the
// feeder can keep reading while a downstream FIFO is full.
module feeder_skid_buffer
   import pe_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  tag_t                  i_wr_tag,
   input  logic                  i_pop,
   output logic                  o_head_valid,
   output logic [DATA_WIDTH-1:0] o_head_data,
   output tag_t                  o_head_tag,
   output logic [1:0]            o_count
);

   logic [DATA_WIDTH-1:0] r_data [2];
   tag_t                  r_tag  [2];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;

   // The issue logic upstream guarantees a write never lands on a full buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            r_data[i] <= '0;
            r_tag[i]  <= TAG_FILTER;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_wr_en) begin
            r_data[r_wr_ptr] <= i_wr_data;
            r_tag[r_wr_ptr]  <= i_wr_tag;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (i_pop)
            r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, i_wr_en} - {1'b0, i_pop};
      end
   end

   assign o_head_valid = (r_count != 2'd0);
   assign o_head_data  = r_data[r_rd_ptr];
   assign o_head_tag   = r_tag[r_rd_ptr];
   assign o_count      = r_count;

endmodule

// File: rtl/pe_feeder.sv
// Moves filter, ifmap and ipsum words from the global buffer into the PE
// input FIFOs, one read per cycle, with a skid buffer absorbing backpressure.
module pe_feeder
   import pe_feeder_pkg::*;
#(
   parameter int GLB_ADDR_WIDTH   = 12,
   parameter int GLB_DATA_WIDTH   = 64,
   parameter int DATA_WIDTH_IFMAP = 16,
   parameter int COUNT_WIDTH      = 10
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   input  logic [GLB_ADDR_WIDTH-1:0]   filter_base,
   input  logic [GLB_ADDR_WIDTH-1:0]   ifmap_base,
   input  logic [GLB_ADDR_WIDTH-1:0]   ipsum_base,
   input  logic [COUNT_WIDTH-1:0]      filter_count,
   input  logic [COUNT_WIDTH-1:0]      ifmap_count,
   input  logic [COUNT_WIDTH-1:0]      ipsum_count,
   output logic                        glb_rd_en,
   output logic [GLB_ADDR_WIDTH-1:0]   glb_rd_addr,
   input  logic [GLB_DATA_WIDTH-1:0]   glb_rd_data,
   output logic [GLB_DATA_WIDTH-1:0]   filter,
   output logic                        push_filter,
   input  logic                        filter_fifo_full,
   output logic [DATA_WIDTH_IFMAP-1:0] ifmap,
   output logic                        push_ifmap,
   input  logic                        ifmap_fifo_full,
   output logic [GLB_DATA_WIDTH-1:0]   ipsum,
   output logic                        push_ipsum,
   input  logic                        ipsum_fifo_full
);

   state_t                    r_state;
   logic                      r_busy;
   logic                      r_done;
   logic [GLB_ADDR_WIDTH-1:0] r_addr;
   logic [COUNT_WIDTH-1:0]    r_remaining;
   logic [GLB_ADDR_WIDTH-1:0] r_filter_base;
   logic [GLB_ADDR_WIDTH-1:0] r_ifmap_base;
   logic [GLB_ADDR_WIDTH-1:0] r_ipsum_base;
   logic [COUNT_WIDTH-1:0]    r_filter_count;
   logic [COUNT_WIDTH-1:0]    r_ifmap_count;
   logic [COUNT_WIDTH-1:0]    r_ipsum_count;
   logic                      r_inflight;
   tag_t                      r_inflight_tag;

   logic                      w_in_idle;
   logic                      w_stream_state;
   logic                      w_has_filter;
   logic                      w_has_ifmap;
   logic                      w_has_ipsum;
   state_t                    w_next_stream;
   logic [GLB_ADDR_WIDTH-1:0] w_next_base;
   logic [COUNT_WIDTH-1:0]    w_next_count;
   logic                      w_head_valid;
   logic [GLB_DATA_WIDTH-1:0] w_head_data;
   tag_t                      w_head_tag;
   logic [1:0]                w_skid_count;
   logic                      w_push;
   logic                      w_rd_en;

   // While idle the next stream is chosen from the live inputs, since the
   // latched copies are only written on the accepting edge.
   assign w_in_idle      = (r_state == IDLE);
   assign w_stream_state = (r_state == FILTER) || (r_state == IFMAP) || (r_state == IPSUM);
   assign w_has_filter   = w_in_idle ? (filter_count != '0) : (r_filter_count != '0);
   assign w_has_ifmap    = w_in_idle ? (ifmap_count  != '0) : (r_ifmap_count  != '0);
   assign w_has_ipsum    = w_in_idle ? (ipsum_count  != '0) : (r_ipsum_count  != '0);
   assign w_next_stream  = nextStream(r_state, w_has_filter, w_has_ifmap, w_has_ipsum);

   always_comb begin
      w_next_base  = r_addr + GLB_ADDR_WIDTH'(1);
      w_next_count = '0;
      case (w_next_stream)
         FILTER: begin
            w_next_base  = w_in_idle ? filter_base  : r_filter_base;
            w_next_count = w_in_idle ? filter_count : r_filter_count;
         end
         IFMAP: begin
            w_next_base  = w_in_idle ? ifmap_base  : r_ifmap_base;
            w_next_count = w_in_idle ? ifmap_count : r_ifmap_count;
         end
         IPSUM: begin
            w_next_base  = w_in_idle ? ipsum_base  : r_ipsum_base;
            w_next_count = w_in_idle ? ipsum_count : r_ipsum_count;
         end
         default: ;
      endcase
   end

   feeder_skid_buffer #(
      .DATA_WIDTH (GLB_DATA_WIDTH)
   ) u_skid (
      .clk          (clk),
      .reset        (reset),
      .i_wr_en      (r_inflight),
      .i_wr_data    (glb_rd_data),
      .i_wr_tag     (r_inflight_tag),
      .i_pop        (w_push),
      .o_head_valid (w_head_valid),
      .o_head_data  (w_head_data),
      .o_head_tag   (w_head_tag),
      .o_count      (w_skid_count)
   );

   assign push_filter = w_head_valid && (w_head_tag == TAG_FILTER) && !filter_fifo_full;
   assign push_ifmap  = w_head_valid && (w_head_tag == TAG_IFMAP)  && !ifmap_fifo_full;
   assign push_ipsum  = w_head_valid && (w_head_tag == TAG_IPSUM)  && !ipsum_fifo_full;
   assign w_push      = push_filter || push_ifmap || push_ipsum;

   // A read is only issued if its word is guaranteed a skid slot on arrival.
   assign w_rd_en = w_stream_state &&
                    (({1'b0, w_skid_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_push}));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_addr         <= '0;
         r_remaining    <= '0;
         r_filter_base  <= '0;
         r_ifmap_base   <= '0;
         r_ipsum_base   <= '0;
         r_filter_count <= '0;
         r_ifmap_count  <= '0;
         r_ipsum_count  <= '0;
         r_inflight     <= 1'b0;
         r_inflight_tag <= TAG_FILTER;
      end else begin
         r_done         <= 1'b0;
         r_inflight     <= w_rd_en;
         r_inflight_tag <= stateTag(r_state);
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_filter_base  <= filter_base;
                  r_ifmap_base   <= ifmap_base;
                  r_ipsum_base   <= ipsum_base;
                  r_filter_count <= filter_count;
                  r_ifmap_count  <= ifmap_count;
                  r_ipsum_count  <= ipsum_count;
                  r_busy         <= 1'b1;
                  if (w_next_stream == DRAIN) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state     <= w_next_stream;
                     r_addr      <= w_next_base;
                     r_remaining <= w_next_count;
                  end
               end
            end
            FILTER, IFMAP, IPSUM: begin
               if (w_rd_en) begin
                  if (r_remaining == COUNT_WIDTH'(1)) begin
                     r_state     <= w_next_stream;
                     r_addr      <= w_next_base;
                     r_remaining <= w_next_count;
                  end else begin
                     r_addr      <= r_addr + GLB_ADDR_WIDTH'(1);
                     r_remaining <= r_remaining - COUNT_WIDTH'(1);
                  end
               end
            end
            DRAIN: begin
               if (w_skid_count == 2'd0 && !r_inflight) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign glb_rd_en   = w_rd_en;
   assign glb_rd_addr = r_addr;
   assign filter      = w_head_data;
   assign ifmap       = w_head_data[DATA_WIDTH_IFMAP-1:0];
   assign ipsum       = w_head_data;

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameters SHALL be: GLB_ADDR_WIDTH, default 12, global-buffer word address width; GLB_DATA_WIDTH, default 64, global-buffer word width; DATA_WIDTH_IFMAP, default 16, ifmap push width; COUNT_WIDTH, default 10, per-stream word-count width.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a transfer; ignored while busy.
REQ-005 busy  output  1  high from the cycle after an accepted start through the done cycle, inclusive.
REQ-006 done  output  1  one-cycle pulse when the transfer is complete.
REQ-007 filter_base, ifmap_base, ipsum_base  input  GLB_ADDR_WIDTH each  first word address of each stream.
REQ-008 filter_count, ifmap_count, ipsum_count  input  COUNT_WIDTH each  words to move per stream; 0 skips that stream.
REQ-009 glb_rd_en  output  1  global-buffer read strobe.
REQ-010 glb_rd_addr  output  GLB_ADDR_WIDTH  read address, valid while glb_rd_en is high.
REQ-011 glb_rd_data  input  GLB_DATA_WIDTH  read data, valid exactly one cycle after glb_rd_en.
REQ-012 filter, push_filter, filter_fifo_full  output GLB_DATA_WIDTH / output 1 / input 1  filter FIFO write port.
REQ-013 ifmap, push_ifmap, ifmap_fifo_full  output DATA_WIDTH_IFMAP / output 1 / input 1  ifmap FIFO write port.
REQ-014 ipsum, push_ipsum, ipsum_fifo_full  output GLB_DATA_WIDTH / output 1 / input 1  ipsum FIFO write port.

Function
REQ-015 FSM states SHALL be IDLE, FILTER, IFMAP, IPSUM, DRAIN, DONE; state order is fixed.
REQ-016 IDLE + start SHALL latch all bases and counts, then enter the first stream state with a nonzero count; if all counts are 0, it SHALL enter DONE.
REQ-017 In each stream state the block SHALL issue reads at consecutive addresses from base; it SHALL advance to the next nonzero stream state (or DRAIN) in the cycle after that stream's last read.
REQ-018 glb_rd_en SHALL assert only when (skid occupancy + reads in flight - push this cycle) < 2.
REQ-019 A 2-entry skid FIFO SHALL capture glb_rd_data with a 2-bit stream tag at the end of the cycle in which it is valid; a word is never dropped or duplicated.
REQ-020 push_X SHALL equal: skid head valid AND head tag == X AND NOT X_fifo_full; the data port carries the head word, and ifmap carries bits [DATA_WIDTH_IFMAP-1:0].
REQ-021 At most one push SHALL occur per cycle; words SHALL leave in read order, so filter words precede ifmap words and ifmap words precede ipsum words.
REQ-022 Backpressure on the head stream SHALL stall all pushes and, via REQ-018, all reads; the block SHALL resume with no lost cycle once full deasserts.
REQ-023 DRAIN SHALL exit to DONE when the skid is empty and no read is in flight; DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-024 Throughput SHALL be 1 word/cycle without backpressure; first push SHALL occur 2 cycles after the first glb_rd_en.
REQ-025 Address counters SHALL wrap modulo 2^GLB_ADDR_WIDTH.
REQ-026 start during busy, including the DONE cycle, SHALL be ignored.

Reset
REQ-027 On reset: state=IDLE; skid empty; in-flight flag cleared; busy, done, glb_rd_en, push_filter, push_ifmap, push_ipsum = 0; glb_rd_addr and data outputs = 0.
REQ-028 Reset mid-transfer SHALL abort it at the next edge: pending words are discarded and done does not pulse.

Structure
REQ-029 Package pe_feeder_pkg SHALL hold the state encoding and the stream tag constants (TAG_FILTER=0, TAG_IFMAP=1, TAG_IPSUM=2).
REQ-030 The 2-entry tagged buffer SHALL be sub-module feeder_skid_buffer; the FSM, counters and issue logic SHALL stay in pe_feeder.

Verification
REQ-031 filter_count=3 at 0x010, ifmap_count=4 at 0x100, ipsum_count=2 at 0x200, fulls low -> 9 pushes in consecutive cycles in order F,F,F,I,I,I,I,P,P with matching data; done exactly once.
REQ-032 filter_count=4 with filter_fifo_full held high for cycles 3-7 -> no push and at most 2 outstanding words during the stall; all 4 words delivered in order after release.
REQ-033 All counts 0 -> busy for 1 cycle, done pulse, no glb_rd_en, no push.
REQ-034 ifmap_base=0xFFE, ifmap_count=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-035 Reset asserted 2 cycles after the first push of a 6-word filter stream -> all outputs 0 next cycle, no done; a new start then runs cleanly.
REQ-036 start pulsed during busy -> no effect on addresses, counts or the done count.
